snax_hwpe_pipe_ctrl: RTL and testbench

Pipelined, parametrised bridge between the SNAX accelerator request/response streams and a 32-bit HWPE peripheral control port. Decodes custom-accelerator and CSR instructions into periph reads and writes, keeps several reads in flight, and buffers read data in a response FIFO with real backpressure on `resp_ready_i`. Sits between the Snitch accelerator interface and the HWPE register file, replacing the single-transaction controller.

---
 rtl/snax_hwpe_pipe_ctrl_if.sv | 55 +++++
 rtl/snax_hwpe_pipe_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_snax_hwpe_pipe_ctrl.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snax_hwpe_pipe_ctrl_if.sv
// Accelerator stream payload types and opcode encodings, plus the HWPE peripheral control port.
package snax_hwpe_pipe_ctrl_pkg;

    localparam int unsigned IdWidth = 5;

    // Requests carry the RISC-V instruction word; only opcode and funct3 are decoded.
    localparam logic [6:0]  OpcSystem   = 7'h73;
    localparam logic [6:0]  OpcSnax     = 7'h2b;
    localparam logic [31:0] SNAX_WR_ACC = 32'h0000_002b;
    localparam logic [31:0] SNAX_RD_ACC = 32'h0000_102b;
    localparam logic [31:0] CSRRW       = 32'h0000_1073;
    localparam logic [31:0] CSRRS       = 32'h0000_2073;
    localparam logic [31:0] CSRRC       = 32'h0000_3073;
    localparam logic [31:0] CSRRWI      = 32'h0000_5073;
    localparam logic [31:0] CSRRSI      = 32'h0000_6073;
    localparam logic [31:0] CSRRCI      = 32'h0000_7073;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic [31:0]        data_op;
        logic [63:0]        data_arga;
        logic [63:0]        data_argb;
    } acc_req_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               error;
        logic [63:0]        data;
    } acc_rsp_t;

endpackage

interface hwpe_ctrl_intf_periph #(
    parameter int unsigned ID_WIDTH = snax_hwpe_pipe_ctrl_pkg::IdWidth
);
    logic                req;
    logic                gnt;
    logic [31:0]         add;
    logic                wen;
    logic [3:0]          be;
    logic [31:0]         data;
    logic [ID_WIDTH-1:0] id;
    logic [31:0]         r_data;
    logic                r_valid;
    logic [ID_WIDTH-1:0] r_id;

    modport master (
        output req, add, wen, be, data, id,
        input  gnt, r_data, r_valid, r_id
    );
    modport slave (
        input  req, add, wen, be, data, id,
        output gnt, r_data, r_valid, r_id
    );
endinterface

// File: rtl/snax_hwpe_pipe_ctrl.sv
// Pipelined SNAX accelerator stream to HWPE periph bridge with outstanding reads and a response FIFO.
// Optional address range check: define SNAX_HWPE_PIPE_CTRL_RANGE_CHECK_EN.
module snax_hwpe_pipe_ctrl #(
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned RespDepth      = 4,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [31:0] CsrBase        = 32'd960,
    parameter int unsigned NumRegs        = 16,
    parameter type acc_req_t = snax_hwpe_pipe_ctrl_pkg::acc_req_t,
    parameter type acc_rsp_t = snax_hwpe_pipe_ctrl_pkg::acc_rsp_t
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  acc_req_t                    req_i,
    input  logic                        req_valid_i,
    output logic                        req_ready_o,
    output acc_rsp_t                    resp_o,
    output logic                        resp_valid_o,
    input  logic                        resp_ready_i,
    hwpe_ctrl_intf_periph.master        periph
);
    import snax_hwpe_pipe_ctrl_pkg::*;

    localparam int unsigned PtrW = (RespDepth > 1) ? $clog2(RespDepth) : 1;
    localparam int unsigned CntW = $clog2(RespDepth + 1);
    localparam int unsigned InfW = $clog2(MaxOutstanding + 1);

    // Request decode
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        req_csr, req_rd;
    logic [31:0] req_add;

    assign opcode  = req_i.data_op[6:0];
    assign funct3  = req_i.data_op[14:12];
    assign req_csr = (opcode == OpcSystem) && (funct3 != 3'b000) && (funct3 != 3'b100);
    assign req_rd  = ((opcode == OpcSnax) && (funct3 == 3'b001)) || (req_csr && funct3[1]);
    assign req_add = req_csr ? ((req_i.data_arga[31:0] - CsrBase) << 2) : req_i.data_arga[31:0];

    logic unused_req_bits;
    assign unused_req_bits = ^{req_i.data_op[31:15], req_i.data_op[11:7],
                               req_i.data_arga[63:32], req_i.data_argb[63:32]};

    // Request slot and credit state
    logic               slot_req, slot_wen;
    logic [31:0]        slot_add, slot_data;
    logic [3:0]         slot_be;
    logic [IdWidth-1:0] slot_id;
    logic [InfW-1:0]    inflight;
    logic [CntW-1:0]    fifo_count;
    logic               slot_free, slot_read, accept, fwd;
    logic               err_valid;
    acc_rsp_t           err_rsp;
    logic [31:0]        used_out, used_resp;

    assign slot_free = ~slot_req | periph.gnt;
    assign slot_read = slot_req & slot_wen;
    assign accept    = req_valid_i & req_ready_o;

    always_comb begin
        used_out  = 32'(inflight) + 32'(slot_read);
        used_resp = used_out + 32'(fifo_count);
    end

    assign req_ready_o = slot_free & ~err_valid & (used_resp < RespDepth) & (used_out < MaxOutstanding);

`ifdef SNAX_HWPE_PIPE_CTRL_RANGE_CHECK_EN
    logic     out_of_range, err_load, err_pushed;
    acc_rsp_t err_new;

    assign out_of_range = (req_add >> 2) >= NumRegs;
    assign fwd          = accept & ~out_of_range;
    assign err_load     = accept & out_of_range & req_rd;

    always_comb begin
        err_new       = '0;
        err_new.id    = req_i.id;
        err_new.error = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_valid <= 1'b0;
            err_rsp   <= '0;
        end else if (err_load) begin
            err_valid <= 1'b1;
            err_rsp   <= err_new;
        end else if (err_pushed) begin
            err_valid <= 1'b0;
        end
    end
`else
    logic [31:0] unused_numregs;
    assign unused_numregs = NumRegs;
    assign fwd            = accept;
    assign err_valid      = 1'b0;
    assign err_rsp        = '0;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            slot_req  <= 1'b0;
            slot_wen  <= 1'b0;
            slot_add  <= '0;
            slot_data <= '0;
            slot_be   <= '0;
            slot_id   <= '0;
        end else if (fwd) begin
            slot_req  <= 1'b1;
            slot_wen  <= req_rd;
            slot_add  <= req_add;
            slot_data <= req_i.data_argb[31:0];
            slot_be   <= req_rd ? 4'h0 : 4'hF;
            slot_id   <= IdWidth'(req_i.id);
        end else if (periph.gnt) begin
            slot_req  <= 1'b0;
        end
    end

    assign periph.req  = slot_req;
    assign periph.wen  = slot_wen;
    assign periph.add  = slot_add;
    assign periph.data = slot_data;
    assign periph.be   = slot_be;
    assign periph.id   = slot_id;

    // Returns with nothing outstanding (e.g. stale after reset) are dropped
    logic inf_inc, ret_ok;
    assign inf_inc = slot_req & periph.gnt & slot_wen;
    assign ret_ok  = periph.r_valid & (inflight != '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight <= '0;
        end else if (inf_inc & ~ret_ok) begin
            inflight <= inflight + InfW'(1);
        end else if (~inf_inc & ret_ok) begin
            inflight <= inflight - InfW'(1);
        end
    end

    // Response FIFO; periph returns take priority over a pending local error
    acc_rsp_t        mem [RespDepth];
    acc_rsp_t        ret_rsp, push_rsp;
    logic [PtrW-1:0] wr_ptr, rd_ptr;
    logic            push, pop;

    always_comb begin
        ret_rsp      = '0;
        ret_rsp.id   = periph.r_id;
        ret_rsp.data = DataWidth'(periph.r_data);
        push         = ret_ok | err_valid;
        push_rsp     = ret_ok ? ret_rsp : err_rsp;
    end

`ifdef SNAX_HWPE_PIPE_CTRL_RANGE_CHECK_EN
    assign err_pushed = err_valid & ~ret_ok;
`endif

    assign resp_valid_o = (fifo_count != '0);
    assign pop          = resp_valid_o & resp_ready_i;
    assign resp_o       = resp_valid_o ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_rsp;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PtrW'(RespDepth - 1)) ? '0 : wr_ptr + PtrW'(1);
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PtrW'(RespDepth - 1)) ? '0 : rd_ptr + PtrW'(1);
            end
            if (push & ~pop) begin
                fifo_count <= fifo_count + CntW'(1);
            end else if (~push & pop) begin
                fifo_count <= fifo_count - CntW'(1);
            end
        end
    end

endmodule

// File: tb/tb_snax_hwpe_pipe_ctrl.sv
// Self-checking bench for snax_hwpe_pipe_ctrl: decode vector table, response scoreboard, corner sequences.
module tb_snax_hwpe_pipe_ctrl;
    import snax_hwpe_pipe_ctrl_pkg::*;

    logic     clk, rst;
    acc_req_t req;
    logic     req_valid, req_ready;
    acc_rsp_t resp;
    logic     resp_valid, resp_ready;

    hwpe_ctrl_intf_periph periph ();

    snax_hwpe_pipe_ctrl #(
        .DataWidth      (64),
        .RespDepth      (4),
        .MaxOutstanding (2),
        .CsrBase        (32'd960),
        .NumRegs        (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .resp_o       (resp),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .periph       (periph)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    acc_rsp_t exp_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) chk({tag, "_ready_timeout"}, 64'(req_ready), 64'd1);
    endtask

    task automatic drive_req(input logic [4:0] id, input logic [31:0] op,
                             input logic [63:0] a, input logic [63:0] b);
        req.id        = id;
        req.data_op   = op;
        req.data_arga = a;
        req.data_argb = b;
        req_valid     = 1'b1;
    endtask

    // Issue one read and wait until it has been granted (gnt held high)
    task automatic issue_read(input logic [4:0] id, input logic [63:0] a);
        wait_ready("issue");
        drive_req(id, SNAX_RD_ACC, a, 64'd0);
        step();
        req_valid = 1'b0;
        step();
    endtask

    task automatic drive_ret(input logic [4:0] id, input logic [31:0] d, input logic expect_it);
        acc_rsp_t e;
        periph.r_valid = 1'b1;
        periph.r_id    = id;
        periph.r_data  = d;
        e       = '0;
        e.id    = id;
        e.data  = {32'h0, d};
        if (expect_it) exp_q.push_back(e);
    endtask

    task automatic clear_ret();
        periph.r_valid = 1'b0;
        periph.r_id    = '0;
        periph.r_data  = '0;
    endtask

    task automatic return_read(input logic [4:0] id, input logic [31:0] d);
        drive_ret(id, d, 1'b1);
        step();
        clear_ret();
    endtask

    // Scoreboard: compare every response popped by the bench
    always @(negedge clk) begin
        if (!rst && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 64'(resp_valid), 64'd0);
            end else begin
                acc_rsp_t e;
                e = exp_q.pop_front();
                chk("resp_id", 64'(resp.id), 64'(e.id));
                chk("resp_error", 64'(resp.error), 64'(e.error));
                chk("resp_data", resp.data, e.data);
            end
        end
    end

    typedef struct {
        logic [31:0] op;
        logic [63:0] arga;
        logic [63:0] argb;
        logic [31:0] add;
        logic        wen;
        logic [3:0]  be;
        logic [31:0] data;
    } vec_t;

    localparam int NV = 9;
    vec_t vec [NV];

    task automatic setv(input int i, input logic [31:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [31:0] add, input logic wen, input logic [31:0] data);
        vec[i].op   = op;
        vec[i].arga = a;
        vec[i].argb = b;
        vec[i].add  = add;
        vec[i].wen  = wen;
        vec[i].be   = wen ? 4'h0 : 4'hF;
        vec[i].data = data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

    bit exp_rdy [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        setv(0, CSRRW,       64'd962,                 64'hDEADBEEF,            32'h8,   1'b0, 32'hDEADBEEF);
        setv(1, SNAX_WR_ACC, 64'h24,                  64'h1_CAFE_F00D,         32'h24,  1'b0, 32'hCAFEF00D);
        setv(2, CSRRWI,      64'd965,                 64'h55,                  32'h14,  1'b0, 32'h55);
        setv(3, 32'h33,      64'h1234_5678_0000_0100, 64'hFFFF_0000_1357_9BDF, 32'h100, 1'b0, 32'h13579BDF);
        setv(4, SNAX_RD_ACC, 64'h10,                  64'd7,                   32'h10,  1'b1, 32'h0);
        setv(5, CSRRS,       64'd961,                 64'd0,                   32'h4,   1'b1, 32'h0);
        setv(6, CSRRC,       64'd975,                 64'd0,                   32'h3C,  1'b1, 32'h0);
        setv(7, CSRRSI,      64'd960,                 64'd0,                   32'h0,   1'b1, 32'h0);
        setv(8, CSRRCI,      64'd963,                 64'd0,                   32'h0C,  1'b1, 32'h0);

        rst = 1'b1;
        req = '0;
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        periph.gnt = 1'b1;
        clear_ret();

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(req_ready), 64'd1);
        chk("rst_preq", 64'(periph.req), 64'd0);
        chk("rst_add", 64'(periph.add), 64'd0);
        chk("rst_be_wen", 64'({periph.be, periph.wen}), 64'd0);
        chk("rst_data_id", 64'({periph.data, periph.id}), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp", 64'({resp.id, resp.error}) | resp.data, 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 64'(req_ready), 64'd1);
        step();

        // Decode table with an always-granting slave
        for (int i = 0; i < NV; i++) begin
            wait_ready("vec");
            drive_req(5'(i + 1), vec[i].op, vec[i].arga, vec[i].argb);
            step();
            req_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_req", i), 64'(periph.req), 64'd1);
            chk($sformatf("vec%0d_add", i), 64'(periph.add), 64'(vec[i].add));
            chk($sformatf("vec%0d_wen", i), 64'(periph.wen), 64'(vec[i].wen));
            chk($sformatf("vec%0d_be", i), 64'(periph.be), 64'(vec[i].be));
            chk($sformatf("vec%0d_id", i), 64'(periph.id), 64'(i + 1));
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'd1);
            if (!vec[i].wen) chk($sformatf("vec%0d_data", i), 64'(periph.data), 64'(vec[i].data));
            step();
            if (vec[i].wen) return_read(5'(i + 1), 32'h8000_0000 | 32'(i));
            repeat (2) step();
        end

        // Read latency and hold under backpressure
        resp_ready = 1'b0;
        wait_ready("lat");
        drive_req(5'd3, SNAX_RD_ACC, 64'h10, 64'd0);
        step();
        req_valid = 1'b0;
        step();
        step();
        drive_ret(5'd3, 32'h1234, 1'b1);
        @(negedge clk);
        chk("lat_not_yet", 64'(resp_valid), 64'd0);
        step();
        clear_ret();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("lat_valid", 64'(resp_valid), 64'd1);
            chk("lat_id", 64'(resp.id), 64'd3);
            chk("lat_data", resp.data, 64'h1234);
            step();
        end
        resp_ready = 1'b1;
        step();
        @(negedge clk);
        chk("lat_popped", 64'(resp_valid), 64'd0);
        chk("lat_empty_zero", resp.data | 64'(resp.id), 64'd0);
        step();

        // Outstanding read limit, then grant and return in the same cycle
        drive_req(5'd10, SNAX_RD_ACC, 64'h0, 64'd0);
        for (int k = 0; k < 5; k++) begin
            logic acc;
            @(negedge clk);
            chk($sformatf("maxout_ready%0d", k), 64'(req_ready), 64'(exp_rdy[k]));
            acc = req_ready;
            step();
            if (acc) req.id = req.id + 5'd1;
        end
        drive_ret(5'd10, 32'hA, 1'b1);
        @(negedge clk);
        chk("maxout_ret_cycle", 64'(req_ready), 64'd0);
        step();
        clear_ret();
        @(negedge clk);
        chk("maxout_freed", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        drive_ret(5'd11, 32'hB, 1'b1);
        @(negedge clk);
        chk("gnt_rvalid_same", 64'(req_ready), 64'd0);
        step();
        clear_ret();
        @(negedge clk);
        chk("inflight_kept", 64'(req_ready), 64'd1);
        step();
        return_read(5'd12, 32'hC);
        repeat (3) step();

        // Full FIFO blocks requests; one pop frees a credit, order preserved
        resp_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            issue_read(5'(20 + k), 64'(4 * k));
            return_read(5'(20 + k), 32'h100 + 32'(k));
        end
        drive_req(5'd30, SNAX_RD_ACC, 64'h8, 64'd0);
        @(negedge clk);
        chk("full_ready0", 64'(req_ready), 64'd0);
        step();
        @(negedge clk);
        chk("full_ready1", 64'(req_ready), 64'd0);
        step();
        resp_ready = 1'b1;
        @(negedge clk);
        chk("full_pop_cycle", 64'(req_ready), 64'd0);
        step();
        resp_ready = 1'b0;
        @(negedge clk);
        chk("full_after_pop", 64'(req_ready), 64'd1);
        step();
        req_valid = 1'b0;
        step();
        return_read(5'd30, 32'h1FF);
        resp_ready = 1'b1;
        repeat (8) step();

        // Reset mid-transaction drops slot, inflight count and FIFO
        resp_ready = 1'b0;
        issue_read(5'd8, 64'h0);
        issue_read(5'd9, 64'h4);
        return_read(5'd8, 32'h55);
        periph.gnt = 1'b0;
        wait_ready("rstmid");
        drive_req(5'd14, SNAX_RD_ACC, 64'h18, 64'd0);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_held", 64'(periph.req), 64'd1);
        rst = 1'b1;
        #1;
        chk("rstmid_preq", 64'(periph.req), 64'd0);
        chk("rstmid_add", 64'(periph.add), 64'd0);
        chk("rstmid_resp_valid", 64'(resp_valid), 64'd0);
        chk("rstmid_resp", resp.data | 64'(resp.id), 64'd0);
        chk("rstmid_ready", 64'(req_ready), 64'd1);
        exp_q.delete();
        periph.gnt = 1'b1;
        step();
        step();
        rst = 1'b0;
        resp_ready = 1'b1;
        drive_ret(5'd9, 32'h77, 1'b0);
        step();
        clear_ret();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("late_ret_ignored", 64'(resp_valid), 64'd0);
            step();
        end

`ifdef SNAX_HWPE_PIPE_CTRL_RANGE_CHECK_EN
        wait_ready("rng_wr");
        drive_req(5'd6, CSRRW, 64'd980, 64'h1111);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rng_wr_dropped", 64'(periph.req), 64'd0);
        step();
        wait_ready("rng_rd");
        drive_req(5'd9, CSRRS, 64'd976, 64'd0);
        begin
            acc_rsp_t e;
            e = '0;
            e.id = 5'd9;
            e.error = 1'b1;
            exp_q.push_back(e);
        end
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("rng_rd_no_req", 64'(periph.req), 64'd0);
        chk("rng_err_blocks", 64'(req_ready), 64'd0);
        step();
        step();
        @(negedge clk);
        chk("rng_err_valid", 64'(resp_valid), 64'd1);
        chk("rng_err_flag", 64'(resp.error), 64'd1);
        repeat (3) step();
`else
        wait_ready("norng");
        drive_req(5'd9, CSRRS, 64'd976, 64'd0);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        chk("norng_req", 64'(periph.req), 64'd1);
        chk("norng_add", 64'(periph.add), 64'h40);
        chk("norng_wen", 64'(periph.wen), 64'd1);
        step();
        return_read(5'd9, 32'hABC);
        repeat (3) step();
`endif

        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
